chunked_logic_unit: RTL and testbench

CHUNKED_LOGIC_UNIT -- requirements
Module: chunked_logic_unit

---
 rtl/chunked_logic_unit.sv | 180 ++++++++++++++++++
 tb/tb_chunked_logic_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_logic_unit.sv
// chunked_logic_unit: bitwise AND/OR/XOR/NAND of two WIDTH-bit operands,
// evaluated CHUNK bits per clock so the result is built up over WIDTH/CHUNK
// RUN cycles. The result register o only updates once the whole result is
// ready.
//
// Optional feature: define CHUNKED_LOGIC_UNIT_FLAGS_EN to build registered
// zero (z) and sign (n) flags. Without it, z and n are tied to 0.
//
// Ports:
//   clk   - clock; all state changes on the rising edge
//   rst   - asynchronous active-high reset
//   start - begin an operation; only looked at while idle
//   op    - 00 AND, 01 OR, 10 XOR, 11 NAND
//   a, b  - operands; captured when start is accepted
//   o     - result of the last completed operation
//   busy  - high while an operation is in flight (RUN and DONE)
//   done  - one-cycle pulse when o has just been updated
//   z     - zero flag of the last result (flags build only)
//   n     - MSB of the last result (flags build only)
module chunked_logic_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] o,
    output logic             busy,
    output logic             done,
    output logic             z,
    output logic             n
);

    localparam int unsigned NCH   = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCH - 1);
    localparam logic [WIDTH-1:0] CHUNK_ONES = WIDTH'({CHUNK{1'b1}});

    logic [1:0]       state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [1:0]       op_q,     op_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] o_q,      o_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [WIDTH-1:0] res_full;
    logic [WIDTH-1:0] chunk_mask;
    logic [WIDTH-1:0] shadow_merged;

    // Full-width result of the latched operation; only the current chunk is used.
    always_comb begin
        res_full = '0;
        case (op_q)
            OP_AND:  res_full = a_q & b_q;
            OP_OR:   res_full = a_q | b_q;
            OP_XOR:  res_full = a_q ^ b_q;
            default: res_full = ~(a_q & b_q);
        endcase
    end

    // Merge the current chunk into the shadow result; bitwise ops need no carry.
    always_comb begin
        chunk_mask    = CHUNK_ONES << (32'(idx_q) * CHUNK);
        shadow_merged = (shadow_q & ~chunk_mask) | (res_full & chunk_mask);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            o_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            o_q      <= o_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;
        o_d      = o_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    shadow_d = '0;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                shadow_d = shadow_merged;
                if (idx_q == LAST_IDX) begin
                    // Last chunk: publish the complete result in the same edge.
                    idx_d   = '0;
                    o_d     = shadow_merged;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = IDX_W'(idx_q + 1'b1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign o    = o_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef CHUNKED_LOGIC_UNIT_FLAGS_EN
    logic z_q;
    logic n_q;

    // Flags load together with o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else if (done_d) begin
            z_q <= (shadow_merged == '0);
            n_q <= shadow_merged[WIDTH-1];
        end
    end

    assign z = z_q;
    assign n = n_q;
`else
    assign z = 1'b0;
    assign n = 1'b0;
`endif

endmodule

// File: tb/tb_chunked_logic_unit.sv
// Bench for chunked_logic_unit: three instances (8/4, 8/2, 16/16) sharing
// clock and reset; each has its own expected-result queue checked on done.
module tb_chunked_logic_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        st0, st1, st2;

    logic [7:0]  o0, o1;
    logic [15:0] o2;
    logic        busy0, done0, z0, n0;
    logic        busy1, done1, z1, n1;
    logic        busy2, done2, z2, n2;

    int checks = 0;
    int errors = 0;
    int dn0 = 0, dn1 = 0, dn2 = 0;

    typedef struct packed {
        logic [15:0] o;
        logic        z;
        logic        n;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    chunked_logic_unit #(.WIDTH(8), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst), .start(st0), .op(op), .a(a[7:0]), .b(b[7:0]),
        .o(o0), .busy(busy0), .done(done0), .z(z0), .n(n0)
    );

    chunked_logic_unit #(.WIDTH(8), .CHUNK(2)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .op(op), .a(a[7:0]), .b(b[7:0]),
        .o(o1), .busy(busy1), .done(done1), .z(z1), .n(n1)
    );

    chunked_logic_unit #(.WIDTH(16), .CHUNK(16)) dut2 (
        .clk(clk), .rst(rst), .start(st2), .op(op), .a(a), .b(b),
        .o(o2), .busy(busy2), .done(done2), .z(z2), .n(n2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of one complete operation.
    function automatic exp_t model(input logic [1:0] op_, input logic [15:0] a_,
                                   input logic [15:0] b_, input int w);
        exp_t        e;
        logic [15:0] r;
        logic [15:0] m;
        m = (w == 16) ? 16'hFFFF : 16'h00FF;
        case (op_)
            2'b00:   r = a_ & b_;
            2'b01:   r = a_ | b_;
            2'b10:   r = a_ ^ b_;
            default: r = ~(a_ & b_);
        endcase
        r   = r & m;
        e.o = r;
`ifdef CHUNKED_LOGIC_UNIT_FLAGS_EN
        e.z = (r == 16'h0000);
        e.n = r[w-1];
`else
        e.z = 1'b0;
        e.n = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 0) ? busy0 : (which == 1) ? busy1 : busy2;
    endfunction

    function automatic logic get_done(input int which);
        return (which == 0) ? done0 : (which == 1) ? done1 : done2;
    endfunction

    // Output monitors: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done0) begin
            exp_t e;
            dn0++;
            if (q0.size() == 0) check("dut0_spurious_done", 32'(done0), 32'd0);
            else begin
                e = q0.pop_front();
                check("dut0_o", 32'(o0), 32'(e.o));
                check("dut0_z", 32'(z0), 32'(e.z));
                check("dut0_n", 32'(n0), 32'(e.n));
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            exp_t e;
            dn1++;
            if (q1.size() == 0) check("dut1_spurious_done", 32'(done1), 32'd0);
            else begin
                e = q1.pop_front();
                check("dut1_o", 32'(o1), 32'(e.o));
                check("dut1_z", 32'(z1), 32'(e.z));
                check("dut1_n", 32'(n1), 32'(e.n));
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            exp_t e;
            dn2++;
            if (q2.size() == 0) check("dut2_spurious_done", 32'(done2), 32'd0);
            else begin
                e = q2.pop_front();
                check("dut2_o", 32'(o2), 32'(e.o));
                check("dut2_z", 32'(z2), 32'(e.z));
                check("dut2_n", 32'(n2), 32'(e.n));
            end
        end
    end

    // Issue one operation on the selected instance and check its timing.
    task automatic do_op(input int which, input logic [1:0] op_,
                         input logic [15:0] a_, input logic [15:0] b_);
        int nch;
        int w;
        int cyc;
        int bcnt;
        w   = (which == 2) ? 16 : 8;
        nch = (which == 0) ? 2 : (which == 1) ? 4 : 1;
        @(negedge clk);
        op = op_; a = a_; b = b_;
        case (which)
            0:       begin st0 = 1'b1; q0.push_back(model(op_, a_, b_, w)); end
            1:       begin st1 = 1'b1; q1.push_back(model(op_, a_, b_, w)); end
            default: begin st2 = 1'b1; q2.push_back(model(op_, a_, b_, w)); end
        endcase
        @(negedge clk);
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        bcnt = 0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (get_busy(which)) bcnt++;
            if (get_done(which)) break;
            @(negedge clk);
        end
        check("latency", 32'(cyc), 32'(nch + 1));
        check("busy_cycles", 32'(bcnt), 32'(nch + 1));
        @(negedge clk);
        check("busy_after_done", 32'(get_busy(which)), 32'd0);
    endtask

    initial begin
        int d;
        rst = 1'b1;
        op  = 2'b00; a = '0; b = '0;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        #1;
        check("rst_o0", 32'(o0), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_z0", 32'(z0), 32'd0);
        check("rst_n0", 32'(n0), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic AND, 8/4.
        do_op(0, 2'b00, 16'h00F0, 16'h003C);
        // Idle hold: inputs change, o keeps the last result.
        @(negedge clk);
        a = 16'h0055; b = 16'h00AA; op = 2'b01;
        repeat (2) @(negedge clk);
        check("idle_hold_o0", 32'(o0), 32'h30);

        // XOR to all-ones and AND to zero, 8/2.
        do_op(1, 2'b10, 16'h00AA, 16'h0055);
        do_op(1, 2'b00, 16'h00AA, 16'h0055);

        // Start during RUN is ignored, operand changes do not leak in.
        d = dn0;
        @(negedge clk);
        op = 2'b01; a = 16'h00A5; b = 16'h0011; st0 = 1'b1;
        q0.push_back(model(2'b01, 16'h00A5, 16'h0011, 8));
        @(negedge clk);
        a = 16'h0000; b = 16'h0000; op = 2'b10;
        @(negedge clk);
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        repeat (6) @(negedge clk);
        check("ignored_start_dones", 32'(dn0 - d), 32'd1);
        check("ignored_start_busy", 32'(busy0), 32'd0);

        // Reset mid-RUN aborts without a done pulse.
        do_op(0, 2'b00, 16'h0012, 16'h00FF);
        d = dn0;
        @(negedge clk);
        op = 2'b01; a = 16'h00FF; b = 16'h00FF; st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        check("abort_in_run", 32'(busy0), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_o0", 32'(o0), 32'd0);
        check("abort_busy0", 32'(busy0), 32'd0);
        check("abort_done0", 32'(done0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(dn0 - d), 32'd0);
        do_op(0, 2'b01, 16'h00C0, 16'h0003);

        // Single RUN cycle NAND, then back-to-back starts every 3 cycles, 16/16.
        do_op(2, 2'b11, 16'h1234, 16'hFFFF);
        d = dn2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op = 2'(i); a = 16'h1234 + 16'(i * 16'h1111); b = 16'h0F0F;
            st2 = 1'b1;
            q2.push_back(model(op, a, b, 16));
            @(negedge clk);
            st2 = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("b2b_dones", 32'(dn2 - d), 32'd3);

        // A few random operations on both 8-bit instances.
        for (int i = 0; i < 4; i++) begin
            do_op(0, 2'($urandom), 16'($urandom), 16'($urandom));
            do_op(1, 2'($urandom), 16'($urandom), 16'($urandom));
        end

        repeat (3) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
